// File: rtl/seq_multiply_pkg.sv
// -----------------------------------------------------------------------------
// seq_multiply_pkg
//
// Shared types and helpers for the iterative multiplier.
//   state_e  : controller states (IDLE / BUSY / DONE)
//   MAG_W    : width of the helper datapath used by abs_mag
//   abs_mag  : magnitude of an operand that the caller has already extended
//              to MAG_W bits (sign-extended when signed, zero-extended when not)
// -----------------------------------------------------------------------------
package seq_multiply_pkg;

    // Operands up to 63 bits are supported. The caller extends each operand
    // to this width, so one helper serves both operand widths.
    localparam int unsigned MAG_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Two's-complement magnitude. The most-negative operand yields
    // 2^(W-1), which still fits the unsigned W-bit magnitude after the
    // caller truncates back to the operand width.
    function automatic logic [MAG_W-1:0] abs_mag(
        input logic [MAG_W-1:0] value,
        input logic             is_signed
    );
        if (is_signed && value[MAG_W-1]) begin
            return -value;
        end
        return value;
    endfunction

endpackage

// File: rtl/seq_multiply.sv
// -----------------------------------------------------------------------------
// seq_multiply
//
// Iterative shift-and-add multiplier. The operands are converted to
// magnitudes on accept, one bit of the b-magnitude is retired per clock, and
// the sign is applied on the last iteration. A result takes L2 BUSY cycles.
//
// Parameters
//   L1 : width of operand a (>= 2)
//   L2 : width of operand b and number of iterations (>= 2)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   in_valid   operand pair present
//   in_ready   block can accept operands (decode of IDLE)
//   in1        operand a            [L1-1:0]
//   in2        operand b            [L2-1:0]
//   sgn        1: two's-complement operands, 0: unsigned
//   out_valid  result present (registered)
//   out_ready  consumer takes result
//   out        product              [L1+L2-1:0] (registered, held until the
//              next result is written)
// -----------------------------------------------------------------------------
module seq_multiply
    import seq_multiply_pkg::*;
#(
    parameter int unsigned L1 = 8,
    parameter int unsigned L2 = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [L1-1:0]    in1,
    input  logic [L2-1:0]    in2,
    input  logic             sgn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [L1+L2-1:0] out
);

    localparam int unsigned PW = L1 + L2;          // product width
    localparam int unsigned CW = $clog2(L2) + 1;   // iteration counter width

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e          state_q,     state_d;
    logic [L1-1:0]   a_mag_q,     a_mag_d;
    logic [L2-1:0]   b_mag_q,     b_mag_d;
    logic            neg_q,       neg_d;
    logic [PW-1:0]   acc_q,       acc_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [PW-1:0]   out_q,       out_d;
    logic            out_valid_q, out_valid_d;

    // ------------------------------------------------------------------
    // Operand conditioning
    // ------------------------------------------------------------------
    // Extension is sign-aware only in signed mode; in unsigned mode the
    // zero-extended operand passes through abs_mag unchanged.
    logic [MAG_W-1:0] a_ext;
    logic [MAG_W-1:0] b_ext;

    assign a_ext = {{(MAG_W - L1){sgn & in1[L1-1]}}, in1};
    assign b_ext = {{(MAG_W - L2){sgn & in2[L2-1]}}, in2};

    // ------------------------------------------------------------------
    // Datapath: one partial product per cycle
    // ------------------------------------------------------------------
    logic [PW-1:0] partial;
    logic [PW-1:0] acc_sum;

    // The a-magnitude is shifted by the iteration index rather than kept in
    // a shifting register; the counter already carries that index.
    assign partial = PW'(a_mag_q) << cnt_q;
    assign acc_sum = acc_q + (b_mag_q[0] ? partial : '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d     = state_q;
        a_mag_d     = a_mag_q;
        b_mag_d     = b_mag_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone
                // completes the handshake.
                if (in_valid) begin
                    state_d = BUSY;
                    a_mag_d = L1'(abs_mag(a_ext, sgn));
                    b_mag_d = L2'(abs_mag(b_ext, sgn));
                    neg_d   = sgn & (in1[L1-1] ^ in2[L2-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end

            BUSY: begin
                acc_d   = acc_sum;
                b_mag_d = b_mag_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                // Last iteration: publish the sign-corrected product
                // directly so DONE already presents the final value.
                if (cnt_q == CW'(L2 - 1)) begin
                    state_d     = DONE;
                    out_d       = neg_q ? -acc_sum : acc_sum;
                    out_valid_d = 1'b1;
                end
            end

            DONE: begin
                // in_valid is deliberately ignored here, even in the cycle
                // the result is taken.
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only in clocked blocks, so every
        // flop samples its _d value from before the edge.
        if (!rst_n) begin
            // NOTE: the reset is synchronous and covers every flop,
            // including the operand magnitudes; there is no storage array
            // here that would need to stay out of reset.
            state_q     <= IDLE;
            a_mag_q     <= '0;
            b_mag_q     <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_mag_q     <= a_mag_d;
            b_mag_q     <= b_mag_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: registered or pure state decode
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule

// File: tb/tb_seq_multiply.sv
// -----------------------------------------------------------------------------
// tb_seq_multiply
//
// Two instances: an 8x8 multiplier and a 12x5 multiplier. Expected products
// come from plain signed/unsigned integer arithmetic on the accepted operands.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_seq_multiply;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 8x8 instance
    logic        s_in_valid, s_in_ready, s_sgn, s_out_valid, s_out_ready;
    logic [7:0]  s_in1, s_in2;
    logic [15:0] s_out;

    // 12x5 instance
    logic        w_in_valid, w_in_ready, w_sgn, w_out_valid, w_out_ready;
    logic [11:0] w_in1;
    logic [4:0]  w_in2;
    logic [16:0] w_out;

    int errors = 0;
    int checks = 0;

    seq_multiply #(.L1(8), .L2(8)) u_sq (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in1       (s_in1),
        .in2       (s_in2),
        .sgn       (s_sgn),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out       (s_out)
    );

    seq_multiply #(.L1(12), .L2(5)) u_wide (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in1       (w_in1),
        .in2       (w_in2),
        .sgn       (w_sgn),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out       (w_out)
    );

    // ---------------- reference model ----------------
    function automatic logic [15:0] gold8(input logic [7:0] a, input logic [7:0] b, input logic s);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return 16'(x * y);
    endfunction

    function automatic logic [16:0] gold12(input logic [11:0] a, input logic [4:0] b, input logic s);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return 17'(x * y);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete 8x8 operation with latency and result checks.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s, input string name);
        int n;
        logic [15:0] exp;
        exp = gold8(a, b, s);
        n = 0;
        while (!s_in_ready && n < 40) begin tick(); n++; end
        checks++;
        if (s_in_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_wait: in_ready=%b expected 1", name, s_in_ready);
        end
        s_in1 = a; s_in2 = b; s_sgn = s; s_in_valid = 1'b1;
        tick();                                   // accept edge E
        s_in_valid = 1'b0;
        s_in1 = 8'($urandom); s_in2 = 8'($urandom); s_sgn = 1'($urandom);
        checks++;
        if (s_in_ready !== 1'b0) begin
            errors++; $display("FAIL %s busy_ready: in_ready=%b expected 0", name, s_in_ready);
        end
        n = 0;
        while (s_out_valid !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (n != 8) begin
            errors++; $display("FAIL %s latency: got %0d edges expected 8", name, n);
        end
        checks++;
        if (s_out !== exp) begin
            errors++; $display("FAIL %s product: got %h expected %h", name, s_out, exp);
        end
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        checks++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
            errors++; $display("FAIL %s release: out_valid=%b in_ready=%b expected 0/1",
                               name, s_out_valid, s_in_ready);
        end
    endtask

    // One complete 12x5 operation.
    task automatic run12(input logic [11:0] a, input logic [4:0] b, input logic s, input string name);
        int n;
        logic [16:0] exp;
        exp = gold12(a, b, s);
        n = 0;
        while (!w_in_ready && n < 40) begin tick(); n++; end
        w_in1 = a; w_in2 = b; w_sgn = s; w_in_valid = 1'b1;
        tick();
        w_in_valid = 1'b0;
        w_in1 = 12'($urandom); w_in2 = 5'($urandom); w_sgn = 1'($urandom);
        n = 0;
        while (w_out_valid !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (n != 5) begin
            errors++; $display("FAIL %s latency: got %0d edges expected 5", name, n);
        end
        checks++;
        if (w_out !== exp) begin
            errors++; $display("FAIL %s product: got %h expected %h", name, w_out, exp);
        end
        w_out_ready = 1'b1;
        tick();
        w_out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        s_in_valid = 1'b1; s_in1 = 8'd7; s_in2 = 8'd9; s_sgn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_out !== 16'h0000) begin
                errors++;
                $display("FAIL reset_edge%0d: in_ready=%b out_valid=%b out=%h expected 1/0/0000",
                         i, s_in_ready, s_out_valid, s_out);
            end
        end
        s_in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_no_accept: in_ready=%b out_valid=%b expected 1/0",
                               s_in_ready, s_out_valid);
        end
        checks++;
        if (w_in_ready !== 1'b1 || w_out !== 17'h0) begin
            errors++; $display("FAIL reset_wide: in_ready=%b out=%h expected 1/00000", w_in_ready, w_out);
        end
    endtask

    task automatic test_corners();
        run8(8'd255, 8'd255, 1'b0, "u_255x255");     // 0xFE01
        run8(8'h80,  8'h80,  1'b1, "s_m128xm128");   // 0x4000
        run8(8'h7F,  8'h80,  1'b1, "s_127xm128");    // 0xC080
        run8(8'hFF,  8'h01,  1'b1, "s_m1x1");        // 0xFFFF
        run8(8'h00,  8'hB3,  1'b1, "s_0xm77");       // 0x0000
        run8(8'h80,  8'h80,  1'b0, "u_80x80");       // 0x4000
        run8(8'hFF,  8'h01,  1'b0, "u_FFx01");       // 0x00FF
        checks++;
        if (gold8(8'd255, 8'd255, 1'b0) !== 16'hFE01 || gold8(8'h7F, 8'h80, 1'b1) !== 16'hC080) begin
            errors++; $display("FAIL model_sanity: got %h %h expected FE01 C080",
                               gold8(8'd255, 8'd255, 1'b0), gold8(8'h7F, 8'h80, 1'b1));
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        int n;
        s_in1 = 8'h12; s_in2 = 8'h34; s_sgn = 1'b0; s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        n = 0;
        while (s_out_valid !== 1'b1 && n < 20) begin tick(); n++; end
        held = s_out;
        checks++;
        if (held !== 16'h03A8) begin
            errors++; $display("FAIL bp_product: got %h expected 03a8", held);
        end
        for (int i = 0; i < 5; i++) begin
            s_in_valid = 1'b1; s_in1 = 8'($urandom); s_in2 = 8'($urandom); s_sgn = 1'($urandom);
            tick();
            checks++;
            if (s_out !== 16'h03A8 || s_out_valid !== 1'b1 || s_in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d: out=%h out_valid=%b in_ready=%b expected 03a8/1/0",
                                   i, s_out, s_out_valid, s_in_ready);
            end
        end
        s_in1 = 8'd3; s_in2 = 8'd5; s_sgn = 1'b0; s_in_valid = 1'b1; s_out_ready = 1'b1;
        tick();                                   // DONE -> IDLE, no accept
        s_out_ready = 1'b0;
        checks++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1",
                               s_out_valid, s_in_ready);
        end
        tick();                                   // accept
        s_in_valid = 1'b0;
        checks++;
        if (s_in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_reaccept: in_ready=%b expected 0", s_in_ready);
        end
        n = 0;
        while (s_out_valid !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (n != 8 || s_out !== 16'd15) begin
            errors++; $display("FAIL bp_next: latency=%0d out=%h expected 8/000f", n, s_out);
        end
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        int seen;
        s_in1 = 8'hFF; s_in2 = 8'hFF; s_sgn = 1'b0; s_in_valid = 1'b1;
        tick();                                   // accept
        s_in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (s_out_valid === 1'b1) seen++; end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
            errors++; $display("FAIL midbusy_reset: in_ready=%b out_valid=%b expected 1/0",
                               s_in_ready, s_out_valid);
        end
        for (int i = 0; i < 12; i++) begin tick(); if (s_out_valid === 1'b1) seen++; end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL midbusy_no_valid: out_valid seen %0d cycles expected 0", seen);
        end
        run8(8'd3, 8'd5, 1'b0, "midbusy_3x5");
    endtask

    task automatic test_back_to_back();
        int stamp[$];
        int cyc;
        logic [15:0] exp;
        exp = gold8(8'h9C, 8'h2B, 1'b1);
        s_in1 = 8'h9C; s_in2 = 8'h2B; s_sgn = 1'b1;
        s_in_valid = 1'b1; s_out_ready = 1'b1;
        cyc = 0;
        while (stamp.size() < 3 && cyc < 60) begin
            tick(); cyc++;
            if (s_out_valid === 1'b1) begin
                stamp.push_back(cyc);
                checks++;
                if (s_out !== exp) begin
                    errors++; $display("FAIL b2b_product: got %h expected %h", s_out, exp);
                end
            end
        end
        s_in_valid = 1'b0;
        checks++;
        if (stamp.size() != 3) begin
            errors++; $display("FAIL b2b_count: got %0d results expected 3", stamp.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (stamp[i] - stamp[i-1] != 10) begin
                    errors++; $display("FAIL b2b_period: got %0d cycles expected 10",
                                       stamp[i] - stamp[i-1]);
                end
            end
        end
        for (int i = 0; i < 12; i++) tick();
        s_out_ready = 1'b0;
    endtask

    task automatic test_wide();
        run12(12'h800, 5'd15, 1'b1, "wide_m2048x15");  // 0x18800
        run12(12'hFFF, 5'h1F, 1'b0, "wide_umax");
        run12(12'h800, 5'h10, 1'b1, "wide_minxmin");
        for (int i = 0; i < 100; i++)
            run12(12'($urandom), 5'($urandom), 1'($urandom), "wide_rand");
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), "rand8");
    endtask

    initial begin
        rst_n = 1'b0;
        s_in_valid = 1'b0; s_in1 = '0; s_in2 = '0; s_sgn = 1'b0; s_out_ready = 1'b0;
        w_in_valid = 1'b0; w_in1 = '0; w_in2 = '0; w_sgn = 1'b0; w_out_ready = 1'b0;
        test_reset();
        test_corners();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        test_wide();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
